// File: rtl/corefifo_ptr_pkg.sv
// Shared pointer helpers for the COREFIFO write/read pointer generators.
// Functions work on 32-bit zero-extended vectors; callers slice to their pointer width.
package corefifo_ptr_pkg;

  localparam int ADDRWIDTH_DEF = 3;
  localparam int PTRW          = ADDRWIDTH_DEF + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] x);
    logic [31:0] b;
    b[31] = x[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ x[i];
    end
    return b;
  endfunction

  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  function automatic logic full_match(input logic [31:0] gray_w,
                                      input logic [31:0] gray_r,
                                      input int          w);
    logic [31:0] lap_mask;
    lap_mask = 32'd3 << (w - 2);
    return gray_w == (gray_r ^ lap_mask);
  endfunction

endpackage

// File: rtl/corefifo_gray_counter.sv
// Binary + Gray pointer counter with increment enable and synchronous reset.
// Gray output is registered; bin_nxt/gray_nxt expose the next-state values.
module corefifo_gray_counter
  import corefifo_ptr_pkg::*;
#(
  parameter int W = PTRW
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         inc,
  output logic [W-1:0] bin,
  output logic [W-1:0] bin_nxt,
  output logic [W-1:0] gray_nxt,
  output logic [W-1:0] gray
);

  logic [31:0] g32;
  logic        unused_g32_hi;

  assign bin_nxt       = bin + {{(W-1){1'b0}}, inc};
  assign g32           = bin2gray(32'(bin_nxt));
  assign gray_nxt      = g32[W-1:0];
  assign unused_g32_hi = ^g32[31:W];

  always_ff @(posedge clk) begin
    if (srst) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_nxt;
      gray <= gray_nxt;
    end
  end

endmodule

// File: rtl/corefifo_wr_ptr_gen.sv
// Write-domain pointer generator: RAM write strobe/address, registered Gray pointer and full/afull/overflow flags, 1 clk latency.
// Optional occupancy register wrcnt is built only when COREFIFO_WRCNT_EN is defined; otherwise wrcnt reads 0.
module corefifo_wr_ptr_gen
  import corefifo_ptr_pkg::*;
#(
  parameter int ADDRWIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 we,
  input  logic [ADDRWIDTH:0]   rd_ptr_gray_sync,
  output logic [ADDRWIDTH:0]   wr_ptr_gray,
  output logic [ADDRWIDTH-1:0] waddr,
  output logic                 ram_we,
  output logic                 full,
  output logic                 afull,
  output logic                 overflow,
  output logic [ADDRWIDTH:0]   wrcnt
);

  localparam int          PW  = ADDRWIDTH + 1;
  localparam logic [PW-1:0] AFT = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_nxt;
  logic [PW-1:0] wgray_nxt;
  logic [31:0]   rq_bin32;
  logic [PW-1:0] rq_bin;
  logic [PW-1:0] occ_nxt;
  logic          full_nxt;
  logic          afull_nxt;
  logic          unused_bits;

  // Reset dominates: no RAM write is issued while srst is high.
  assign ram_we = we & ~full & ~srst;
  assign waddr  = wbin[ADDRWIDTH-1:0];

  corefifo_gray_counter #(
    .W (PW)
  ) u_wr_cnt (
    .clk      (clk),
    .srst     (srst),
    .inc      (ram_we),
    .bin      (wbin),
    .bin_nxt  (wbin_nxt),
    .gray_nxt (wgray_nxt),
    .gray     (wr_ptr_gray)
  );

  assign rq_bin32    = gray2bin(32'(rd_ptr_gray_sync));
  assign rq_bin      = rq_bin32[PW-1:0];
  assign occ_nxt     = wbin_nxt - rq_bin;
  assign full_nxt    = full_match(32'(wgray_nxt), 32'(rd_ptr_gray_sync), PW);
  assign afull_nxt   = (occ_nxt >= AFT);
  assign unused_bits = ^{wbin[ADDRWIDTH], rq_bin32[31:PW]};

  always_ff @(posedge clk) begin
    if (srst) begin
      full     <= 1'b0;
      afull    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      full     <= full_nxt;
      afull    <= afull_nxt;
      overflow <= we & full;
    end
  end

`ifdef COREFIFO_WRCNT_EN
  always_ff @(posedge clk) begin
    if (srst) begin
      wrcnt <= '0;
    end else begin
      wrcnt <= occ_nxt;
    end
  end
`else
  assign wrcnt = '0;
`endif

endmodule

// File: tb/tb_corefifo_wr_ptr_gen.sv
// Directed bench for corefifo_wr_ptr_gen (ADDRWIDTH=3, AFULL_THRESH=6) with a pointer/flag model and Gray scoreboard.
module tb_corefifo_wr_ptr_gen;

  logic       clk = 1'b0;
  logic       srst;
  logic       we;
  logic [3:0] rd_ptr_gray_sync;
  logic [3:0] wr_ptr_gray;
  logic [2:0] waddr;
  logic       ram_we;
  logic       full;
  logic       afull;
  logic       overflow;
  logic [3:0] wrcnt;

  always #5 clk = ~clk;

  corefifo_wr_ptr_gen #(
    .ADDRWIDTH    (3),
    .AFULL_THRESH (6)
  ) dut (
    .clk              (clk),
    .srst             (srst),
    .we               (we),
    .rd_ptr_gray_sync (rd_ptr_gray_sync),
    .wr_ptr_gray      (wr_ptr_gray),
    .waddr            (waddr),
    .ram_we           (ram_we),
    .full             (full),
    .afull            (afull),
    .overflow         (overflow),
    .wrcnt            (wrcnt)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         mw      = 0;
  int         mr      = 0;
  bit         mfull   = 1'b0;
  logic [3:0] exp_q[$];

  function automatic logic [3:0] g(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input bit we_prev, input bit full_prev);
    int occ;
    occ = (mw - mr) & 15;
    chk("full", full, occ == 8);
    chk("afull", afull, occ >= 6);
    chk("overflow", overflow, we_prev & full_prev);
`ifdef COREFIFO_WRCNT_EN
    chk("wrcnt", wrcnt, occ);
`else
    chk("wrcnt", wrcnt, 0);
`endif
    chk("wr_ptr_gray", wr_ptr_gray, g(mw));
  endtask

  task automatic step(input bit w, input int rb);
    bit acc;
    bit pf;
    srst             = 1'b0;
    we               = w;
    mr               = rb & 15;
    rd_ptr_gray_sync = g(mr);
    #1;
    pf  = mfull;
    acc = w && !mfull;
    chk("ram_we", ram_we, acc);
    if (acc) begin
      chk("waddr", waddr, mw & 7);
      exp_q.push_back(g(mw + 1));
    end
    @(posedge clk);
    #1;
    if (acc) mw = (mw + 1) & 15;
    mfull = (((mw - mr) & 15) == 8);
    check_state(w, pf);
    if (acc) chk("sb_gray", wr_ptr_gray, exp_q.pop_front());
  endtask

  task automatic rst_step();
    srst             = 1'b1;
    we               = 1'b1;
    rd_ptr_gray_sync = 4'b0000;
    #1;
    chk("rst_ram_we", ram_we, 0);
    @(posedge clk);
    #1;
    mw    = 0;
    mr    = 0;
    mfull = 1'b0;
    exp_q.delete();
    check_state(1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] fill_g [8];
    logic [3:0] pg;
    int         hq[$];
    int         rfix;
    bit         wrapped;

    fill_g = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    srst             = 1'b1;
    we               = 1'b1;
    rd_ptr_gray_sync = 4'b0000;

    // Reset held two clocks with a pending write.
    rst_step();
    rst_step();

    // Fill eight entries with the read pointer parked at zero.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 0);
      chk("fill_gray", wr_ptr_gray, fill_g[i]);
    end
    chk("fill_full", full, 1);
    chk("fill_afull", afull, 1);

    // Writes while full are refused and flagged.
    repeat (3) step(1'b1, 0);
    chk("frozen_gray", wr_ptr_gray, 4'b1100);
    step(1'b0, 0);
    chk("overflow_drop", overflow, 0);

    // One read frees a slot; one write refills it.
    step(1'b0, 1);
    chk("full_clear", full, 0);
    step(1'b1, 1);
    chk("refill_gray", wr_ptr_gray, 4'b1101);
    chk("refill_full", full, 1);

    // Wrap the pointer with the reader trailing three writes behind.
    step(1'b0, mw);
    hq      = '{mw, mw, mw};
    pg      = wr_ptr_gray;
    wrapped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      hq.push_back(mw);
      step(1'b1, hq.pop_front());
      chk("hamming", $countones(wr_ptr_gray ^ pg), 1);
      if (pg == 4'b1000 && wr_ptr_gray == 4'b0000) wrapped = 1'b1;
      pg = wr_ptr_gray;
    end
    chk("wrapped", wrapped, 1);

    // Reset in the middle of a burst, then resume.
    step(1'b0, mw);
    rfix = mw;
    repeat (5) step(1'b1, rfix);
    rst_step();
    chk("rst_gray", wr_ptr_gray, 4'b0000);
    chk("rst_afull", afull, 0);
    step(1'b1, 0);
    step(1'b1, 0);
    chk("resume_gray", wr_ptr_gray, 4'b0011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
